// File: rtl/arbitro_vc.sv
// ---------------------------------------------------------------------------
// arbitro_vc
// Weighted round-robin arbiter that moves words from the virtual-channel
// FIFOs into the destination FIFOs of the transmission layer. Each cycle at
// most one non-empty VC whose head word targets a destination that is not
// almost-full is granted. The granted word is popped combinationally and
// pushed, one cycle later, into the destination selected by the word's top
// two bits. Forwarding only happens while the link state machine is active;
// per-VC weights are latched while the link is inactive.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low; 0 clears all state at once
//   active         link state machine active flag; 1 enables forwarding
//   weights        per-VC weight, VC v at [v*W_WIDTH +: W_WIDTH]
//   vc_empty       empty flag of each first-word-fall-through VC FIFO
//   vc_data        head word of each VC FIFO, VC v at [v*DATA_WIDTH +: DATA_WIDTH]
//   d_almost_full  almost-full flag of each destination FIFO
//   vc_pop         one-hot pop strobe (combinational)
//   d_push         one-hot push strobe (registered)
//   d_data         word presented to the destination FIFOs (registered)
//   busy           registered; 1 whenever d_push is nonzero
// ---------------------------------------------------------------------------
module arbitro_vc #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_VC     = 4,
    parameter int NUM_D      = 4,
    parameter int W_WIDTH    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          active,
    input  logic [NUM_VC*W_WIDTH-1:0]     weights,
    input  logic [NUM_VC-1:0]             vc_empty,
    input  logic [NUM_VC*DATA_WIDTH-1:0]  vc_data,
    input  logic [NUM_D-1:0]              d_almost_full,
    output logic [NUM_VC-1:0]             vc_pop,
    output logic [NUM_D-1:0]              d_push,
    output logic [DATA_WIDTH-1:0]         d_data,
    output logic                          busy
);

    localparam int PTR_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int DEST_W = 2;

    // Registered arbitration state
    logic [PTR_W-1:0]   ptr;
    logic [W_WIDTH-1:0] credit;
    logic [W_WIDTH-1:0] wreg [NUM_VC];

    // Combinational arbitration signals
    logic [DEST_W-1:0]     dest [NUM_VC];
    logic [NUM_VC-1:0]     elig;
    logic                  grant_valid;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      cand;
    logic [W_WIDTH-1:0]    eff_weight;
    logic [W_WIDTH-1:0]    credit_next;
    logic [DATA_WIDTH-1:0] grant_word;
    logic [DEST_W-1:0]     grant_dest;
    logic [NUM_D-1:0]      push_onehot;

    // Destination of each head word and per-VC eligibility. Reset is folded
    // in so that vc_pop drops to zero the moment reset asserts, even though
    // the registered state it depends on is also being cleared.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            dest[v] = vc_data[v*DATA_WIDTH + DATA_WIDTH - DEST_W +: DEST_W];
            elig[v] = reset & active & ~vc_empty[v] & ~d_almost_full[dest[v]];
        end
    end

    // Grant selection. The current VC keeps the grant while it still has
    // credit; otherwise the search starts at ptr+1 and wraps so that ptr is
    // examined last. A zero weight is promoted to one so no VC is starved.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr;
        cand        = ptr;
        eff_weight  = '0;
        credit_next = credit;
        if (elig[ptr] && (credit != '0)) begin
            grant_valid = 1'b1;
            grant_idx   = ptr;
            credit_next = credit - W_WIDTH'(1);
        end else begin
            for (int i = 1; i <= NUM_VC; i++) begin
                cand = PTR_W'((int'(ptr) + i) % NUM_VC);
                if (!grant_valid && elig[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
            eff_weight = wreg[grant_idx];
            if (eff_weight == '0) begin
                eff_weight = W_WIDTH'(1);
            end
            credit_next = eff_weight - W_WIDTH'(1);
        end
    end

    // Word and destination of the granted VC
    always_comb begin
        grant_word = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (grant_idx == PTR_W'(v)) begin
                grant_word = vc_data[v*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        grant_dest  = dest[grant_idx];
        push_onehot = NUM_D'(1) << grant_dest;
    end

    // Pop strobe goes out in the same cycle as the grant
    always_comb begin
        vc_pop = '0;
        if (grant_valid) begin
            vc_pop[grant_idx] = 1'b1;
        end
    end

    // Arbitration state and registered push. While inactive the weights are
    // re-latched every cycle and credit is cleared, so the next active period
    // starts a fresh search from the VC after the last one granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr    <= PTR_W'(NUM_VC - 1);
            credit <= '0;
            d_push <= '0;
            d_data <= '0;
            busy   <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                wreg[v] <= W_WIDTH'(1);
            end
        end else if (active) begin
            if (grant_valid) begin
                ptr    <= grant_idx;
                credit <= credit_next;
                d_data <= grant_word;
                d_push <= push_onehot;
                busy   <= 1'b1;
            end else begin
                d_push <= '0;
                busy   <= 1'b0;
            end
        end else begin
            d_push <= '0;
            busy   <= 1'b0;
            credit <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                wreg[v] <= weights[v*W_WIDTH +: W_WIDTH];
            end
        end
    end

endmodule
